// File: rtl/processador_datapath_pkg.sv
// Shared definitions for the processor datapath: opcodes, ACC source and ALU encodings,
// and the instruction field widths.
package proc_pkg;

   localparam int OPC_W = 4;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD = 4'b0000,
      OP_SUB = 4'b0001,
      OP_AND = 4'b0010,
      OP_XOR = 4'b0011,
      OP_JMP = 4'b0100,
      OP_JZ  = 4'b0101,
      OP_STA = 4'b0110,
      OP_LDA = 4'b0111,
      OP_LDI = 4'b1000,
      OP_IN  = 4'b1001,
      OP_OUT = 4'b1010,
      OP_HLT = 4'b1011
   } opcode_e;

   typedef enum logic [1:0] {
      ACC_ALU = 2'b00,
      ACC_MEM = 2'b01,
      ACC_IMM = 2'b10,
      ACC_IN  = 2'b11
   } acc_scr_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_XOR = 2'b11
   } alu_op_e;

endpackage

// File: rtl/processador_datapath_if.sv
// Control word, instruction-ROM bus and I/O between the controller side (master)
// and the datapath (slave).
interface processador_datapath_if
   import proc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   localparam int INSTR_W = OPC_W + ADDR_W;

   logic               pc_scr;
   logic               pc_ld;
   logic               pc_clr;
   logic               ir_ld;
   logic               ir_clr;
   logic               acc_ld;
   logic               acc_clr;
   acc_scr_e           acc_scr;
   alu_op_e            alu_op;
   logic               rout_ld;
   logic               rout_clr;
   logic               wr_en;
   logic [ADDR_W-1:0]  instr_addr;
   logic [INSTR_W-1:0] instr_data;
   logic [DATA_W-1:0]  in_data;
   logic [DATA_W-1:0]  out_data;
   logic               out_valid;
   logic [OPC_W-1:0]   opcode;
   logic               acc_eq_zero;

   modport master (
      output pc_scr, pc_ld, pc_clr, ir_ld, ir_clr, acc_ld, acc_clr, acc_scr, alu_op,
             rout_ld, rout_clr, wr_en, instr_data, in_data,
      input  instr_addr, out_data, out_valid, opcode, acc_eq_zero
   );

   modport slave (
      input  pc_scr, pc_ld, pc_clr, ir_ld, ir_clr, acc_ld, acc_clr, acc_scr, alu_op,
             rout_ld, rout_clr, wr_en, instr_data, in_data,
      output instr_addr, out_data, out_valid, opcode, acc_eq_zero
   );

endinterface

// File: rtl/processador_datapath_ram.sv
// Data RAM: 2^ADDR_W words, asynchronous read, synchronous write, no reset.
module proc_data_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
   end

   // Read of the address being written this cycle sees the pre-edge contents.
   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/processador_datapath.sv
// Processor datapath: PC, IR, ACC, ROUT and data RAM, driven by the controller's
// control word; returns opcode and acc_eq_zero to the controller.
module processador_datapath
   import proc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input logic                   clk,
   input logic                   rst,
   processador_datapath_if.slave bus
);

   localparam int INSTR_W = OPC_W + ADDR_W;

   logic [ADDR_W-1:0]  pc_q,   pc_d;
   logic [INSTR_W-1:0] ir_q,   ir_d;
   logic [DATA_W-1:0]  acc_q,  acc_d;
   logic [DATA_W-1:0]  rout_q, rout_d;
   logic               out_valid_q, out_valid_d;

   logic [ADDR_W-1:0]  operand;
   logic [DATA_W-1:0]  mem_rdata;
   logic [DATA_W-1:0]  alu_res;
   logic               mem_we;

   assign operand = ir_q[ADDR_W-1:0];
   // Writes are blocked while reset is held so an in-flight store cannot land.
   assign mem_we  = bus.wr_en & ~rst;

   proc_data_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (mem_we),
      .addr_i  (operand),
      .wdata_i (acc_q),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      alu_res = '0;
      unique case (bus.alu_op)
         ALU_ADD: alu_res = acc_q + mem_rdata;
         ALU_SUB: alu_res = acc_q - mem_rdata;
         ALU_AND: alu_res = acc_q & mem_rdata;
         ALU_XOR: alu_res = acc_q ^ mem_rdata;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (bus.pc_clr)     pc_d = '0;
      else if (bus.pc_ld) pc_d = bus.pc_scr ? operand : pc_q + ADDR_W'(1);

      ir_d = ir_q;
      if (bus.ir_clr)     ir_d = '0;
      else if (bus.ir_ld) ir_d = bus.instr_data;

      acc_d = acc_q;
      if (bus.acc_clr) acc_d = '0;
      else if (bus.acc_ld) begin
         unique case (bus.acc_scr)
            ACC_ALU: acc_d = alu_res;
            ACC_MEM: acc_d = mem_rdata;
            ACC_IMM: acc_d = DATA_W'(operand);
            ACC_IN:  acc_d = bus.in_data;
            default: acc_d = acc_q;
         endcase
      end

      rout_d = rout_q;
      if (bus.rout_clr)     rout_d = '0;
      else if (bus.rout_ld) rout_d = acc_q;

      out_valid_d = bus.rout_ld & ~bus.rout_clr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= '0;
         ir_q        <= '0;
         acc_q       <= '0;
         rout_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         acc_q       <= acc_d;
         rout_q      <= rout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.instr_addr  = pc_q;
   assign bus.opcode      = ir_q[INSTR_W-1 -: OPC_W];
   assign bus.out_data    = rout_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.acc_eq_zero = (acc_q == '0);

endmodule

// File: tb/tb_processador_datapath.sv
// Directed bench for processador_datapath: reset, fetch, ALU wrap, store/load,
// jump/clear priority and output strobe, with hand-computed expectations.
module tb_processador_datapath;
   import proc_pkg::*;

   logic clk;
   logic rst;
   int   nerr;
   int   nchk;

   processador_datapath_if #(.DATA_W(8), .ADDR_W(4)) bus ();

   processador_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      nchk++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s got=%02h expected=%02h", tag, got, exp);
      end
   endtask

   task automatic clear_ctl();
      bus.pc_scr   = 1'b0;
      bus.pc_ld    = 1'b0;
      bus.pc_clr   = 1'b0;
      bus.ir_ld    = 1'b0;
      bus.ir_clr   = 1'b0;
      bus.acc_ld   = 1'b0;
      bus.acc_clr  = 1'b0;
      bus.acc_scr  = ACC_ALU;
      bus.alu_op   = ALU_ADD;
      bus.rout_ld  = 1'b0;
      bus.rout_clr = 1'b0;
      bus.wr_en    = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clear_ctl();
   endtask

   task automatic load_ir(input logic [7:0] w);
      bus.instr_data = w;
      bus.ir_ld      = 1'b1;
      tick();
   endtask

   task automatic set_acc(input logic [7:0] v);
      bus.in_data = v;
      bus.acc_scr = ACC_IN;
      bus.acc_ld  = 1'b1;
      tick();
   endtask

   task automatic alu(input alu_op_e op);
      bus.alu_op  = op;
      bus.acc_scr = ACC_ALU;
      bus.acc_ld  = 1'b1;
      tick();
   endtask

   // Copies ACC into ROUT so it can be observed on out_data.
   task automatic show_acc(input string tag, input logic [7:0] exp);
      bus.rout_ld = 1'b1;
      tick();
      chk(tag, bus.out_data, exp);
   endtask

   initial begin
      nerr = 0;
      nchk = 0;
      rst  = 1'b1;
      clear_ctl();
      bus.instr_data = 8'h00;
      bus.in_data    = 8'h00;
      #2;
      chk("rst_pc",    8'(bus.instr_addr), 8'h00);
      chk("rst_zero",  8'(bus.acc_eq_zero), 8'h01);
      chk("rst_valid", 8'(bus.out_valid), 8'h00);
      #10 rst = 1'b0;

      // Reset during activity
      load_ir(8'h45);
      bus.pc_scr = 1'b1; bus.pc_ld = 1'b1; tick();
      chk("pre_pc", 8'(bus.instr_addr), 8'h05);
      set_acc(8'h3C);
      bus.rout_ld = 1'b1; tick();
      chk("pre_rout",  bus.out_data, 8'h3C);
      chk("pre_valid", 8'(bus.out_valid), 8'h01);
      chk("pre_op",    8'(bus.opcode), 8'h04);
      #2 rst = 1'b1;
      #1;
      chk("mid_pc",    8'(bus.instr_addr), 8'h00);
      chk("mid_op",    8'(bus.opcode), 8'h00);
      chk("mid_zero",  8'(bus.acc_eq_zero), 8'h01);
      chk("mid_rout",  bus.out_data, 8'h00);
      chk("mid_valid", 8'(bus.out_valid), 8'h00);
      #1 rst = 1'b0;

      // Fetch: IR gets ROM[0] and PC increments on the same edge
      bus.instr_data = 8'h83;
      bus.pc_ld = 1'b1; bus.ir_ld = 1'b1; tick();
      chk("fetch_op", 8'(bus.opcode), 8'h08);
      chk("fetch_pc", 8'(bus.instr_addr), 8'h01);
      bus.acc_scr = ACC_IMM; bus.acc_ld = 1'b1; tick();
      chk("ldi_nz", 8'(bus.acc_eq_zero), 8'h00);
      show_acc("ldi_acc", 8'h03);

      // ALU wrap: dmem[2] = 1
      load_ir(8'h62);
      set_acc(8'h01);
      bus.wr_en = 1'b1; tick();
      set_acc(8'hFF);
      alu(ALU_ADD);
      chk("add_wrap_zero", 8'(bus.acc_eq_zero), 8'h01);
      show_acc("add_wrap", 8'h00);
      alu(ALU_SUB);
      chk("sub_wrap_nz", 8'(bus.acc_eq_zero), 8'h00);
      show_acc("sub_wrap", 8'hFF);

      // Store/load and Fibonacci step
      load_ir(8'h64);
      set_acc(8'h05);
      bus.wr_en = 1'b1; tick();
      set_acc(8'h08);
      alu(ALU_ADD);
      show_acc("fib_add", 8'h0D);
      bus.acc_scr = ACC_MEM; bus.acc_ld = 1'b1; tick();
      show_acc("lda", 8'h05);
      set_acc(8'h3C);
      alu(ALU_AND);
      show_acc("and", 8'h04);
      set_acc(8'h3C);
      alu(ALU_XOR);
      show_acc("xor", 8'h39);

      // Store with simultaneous ACC load writes the old ACC
      load_ir(8'h67);
      set_acc(8'h05);
      bus.in_data = 8'h77; bus.acc_scr = ACC_IN; bus.acc_ld = 1'b1; bus.wr_en = 1'b1; tick();
      show_acc("sta_newacc", 8'h77);
      bus.acc_scr = ACC_MEM; bus.acc_ld = 1'b1; tick();
      show_acc("sta_oldacc", 8'h05);

      // Store while reset is held must not land
      set_acc(8'h99);
      bus.wr_en = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      load_ir(8'h67);
      bus.acc_scr = ACC_MEM; bus.acc_ld = 1'b1; tick();
      show_acc("rst_no_write", 8'h05);

      // Jump, PC wrap and clear priority
      load_ir(8'h4A);
      bus.pc_scr = 1'b1; bus.pc_ld = 1'b1; tick();
      chk("jmp_pc", 8'(bus.instr_addr), 8'h0A);
      bus.pc_clr = 1'b1; bus.pc_ld = 1'b1; tick();
      chk("pc_clr_prio", 8'(bus.instr_addr), 8'h00);
      load_ir(8'h4F);
      bus.pc_scr = 1'b1; bus.pc_ld = 1'b1; tick();
      bus.pc_ld = 1'b1; tick();
      chk("pc_wrap", 8'(bus.instr_addr), 8'h00);
      bus.pc_scr = 1'b1; tick();
      chk("pc_scr_noload", 8'(bus.instr_addr), 8'h00);
      bus.instr_data = 8'hB3; bus.ir_ld = 1'b1; bus.ir_clr = 1'b1; tick();
      chk("ir_clr_prio", 8'(bus.opcode), 8'h00);
      bus.acc_clr = 1'b1; bus.in_data = 8'h11; bus.acc_scr = ACC_IN; bus.acc_ld = 1'b1; tick();
      chk("acc_clr_prio", 8'(bus.acc_eq_zero), 8'h01);

      // Output strobe
      set_acc(8'h2A);
      bus.rout_ld = 1'b1; tick();
      chk("out_data",   bus.out_data, 8'h2A);
      chk("out_strobe", 8'(bus.out_valid), 8'h01);
      tick();
      chk("out_strobe_end", 8'(bus.out_valid), 8'h00);
      chk("out_hold",       bus.out_data, 8'h2A);
      bus.rout_ld = 1'b1; bus.rout_clr = 1'b1; tick();
      chk("rout_clr_data",  bus.out_data, 8'h00);
      chk("rout_clr_valid", 8'(bus.out_valid), 8'h00);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
